flush_ctrl: RTL and testbench
=============================

Name: flush_ctrl

Overview:
- Drain-side controller for the scan-memory occupancy counter.
- Monitors `mem_used` and drives the counter's `flush` input.
- Moves buffered units to a downstream receiver over a valid/ready handshake, one beat of 3 or 1 units per cycle, matching the counter's decrement rule.
- Reports completion, units moved, and stall errors to the system FSM.

Parameters:
- HIGH_MARK, 8'd80: occupancy that auto-starts a drain (only with FLUSH_CTRL_AUTO_EN).
- LOW_MARK, 8'd0: drain stops when mem_used <= LOW_MARK.
- STALL_MAX, 16: consecutive no-beat cycles in DRAIN before abort.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- mem_used, input, 8: occupancy from the memory counter, registered there.
- scan, input, 1: scanner write request; the counter gives scan priority over flush.
- start_xfer, input, 1: request a drain, level-sampled in IDLE.
- rx_ready, input, 1: receiver can accept a beat this cycle.
- flush, output, 1: decrement request to the memory counter (combinational).
- tx_valid, output, 1: beat offered to the receiver.
- tx_count, output, 2: units in the offered beat, 3 or 1.
- xfer_busy, output, 1: high while in DRAIN.
- xfer_done, output, 1: one-cycle pulse on normal completion.
- xfer_err, output, 1: one-cycle pulse on stall abort.
- units_sent, output, 8: units moved in the current/last drain, saturating.

Behaviour:
- Reset is asynchronous, active-low.
  - While reset=0: state=IDLE, units_sent=0, stall_cnt=0.
  - All outputs are 0 immediately; flush drops combinationally.
- States: IDLE, DRAIN, DONE, ERR.
- IDLE:
  - Go to DRAIN when start_xfer=1 and mem_used > LOW_MARK.
  - start_xfer with mem_used <= LOW_MARK is ignored: stay IDLE, no pulse.
  - On entry to DRAIN: units_sent <= 0, stall_cnt <= 0.
- DRAIN outputs:
  - tx_valid = (mem_used > LOW_MARK).
  - tx_count = 3 if mem_used > 2, else 1.
  - xfer_busy = 1.
- Beat: fires when tx_valid & rx_ready & ~scan.
  - flush = beat, combinational and same cycle, so the counter decrements exactly when the receiver takes the data.
  - Since scan has priority in the counter, flush is never asserted alongside scan.
- On each beat:
  - units_sent <= min(units_sent + tx_count, 255).
  - stall_cnt <= 0.
  - The next cycle sees the updated mem_used, so back-to-back beats every cycle are legal.
- DRAIN, no beat while tx_valid=1 (rx_ready low or scan high):
  - stall_cnt increments.
  - When stall_cnt reaches STALL_MAX-1 and this cycle also stalls, go to ERR.
  - Net effect: STALL_MAX consecutive stall cycles → ERR.
- DRAIN with mem_used <= LOW_MARK (tx_valid=0): go to DONE next edge.
- Occupancy rising during DRAIN (scans) is allowed; draining continues until LOW_MARK.
- DONE: xfer_done=1 for one cycle, then IDLE.
- ERR: xfer_err=1 for one cycle, then IDLE.
- units_sent holds its value in IDLE until the next DRAIN entry.
- stall_cnt width: $clog2(STALL_MAX+1).
- tx_count is 0 whenever tx_valid=0.

Optional Feature:
- Macro: FLUSH_CTRL_AUTO_EN.
- Defined: IDLE also enters DRAIN when mem_used >= HIGH_MARK, with no start_xfer needed.
- Undefined: only start_xfer starts a drain; HIGH_MARK is unused.

Test Plan:
- Bench instantiates flush_ctrl with the memory counter as a live model.
- Reset: reset=0 mid-cycle → flush, tx_valid, xfer_busy, units_sent all 0 immediately; state IDLE after release.
- Normal drain: scan 10 units, start_xfer, rx_ready=1 → 4 consecutive flush cycles with tx_count 3,3,3,1; mem_used 10→7→4→1→0; xfer_done pulse the cycle after mem_used=0; units_sent=10.
- Backpressure: as above with rx_ready=0 for 3 cycles after the first beat → flush low, mem_used holds at 7, drain resumes, units_sent=10, no xfer_err.
- Stall abort: mem_used=5, start_xfer, rx_ready=0 held → xfer_err pulse after 16 stall cycles; mem_used stays 5; units_sent=0; back to IDLE.
- Scan collision: drain from 20 with scan=1 for 2 cycles mid-drain → flush=0 those cycles; mem_used +1 each; drain completes at 0; units_sent=22.
- Auto start (macro defined): scan until mem_used=80, start_xfer=0 → DRAIN entered, drains to 0, xfer_done. Macro undefined: stays IDLE at 80.

Source files
------------

// File: rtl/flush_ctrl.sv
// Drain-side controller for the scan-memory occupancy counter: moves 3- or 1-unit beats
// to a receiver, drives the counter's flush input. FLUSH_CTRL_AUTO_EN enables high-mark auto-start.
module flush_ctrl #(
  parameter logic [7:0] HIGH_MARK = 8'd80,
  parameter logic [7:0] LOW_MARK  = 8'd0,
  parameter int         STALL_MAX = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] mem_used,
  input  logic       scan,
  input  logic       start_xfer,
  input  logic       rx_ready,
  output logic       flush,
  output logic       tx_valid,
  output logic [1:0] tx_count,
  output logic       xfer_busy,
  output logic       xfer_done,
  output logic       xfer_err,
  output logic [7:0] units_sent
);

  localparam int SW = $clog2(STALL_MAX + 1);

`ifdef FLUSH_CTRL_AUTO_EN
  localparam bit AUTO_EN = 1'b1;
`else
  localparam bit AUTO_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [SW-1:0]   stall_cnt_r;
  logic [7:0]      units_sent_r;

  logic            have_data_s;
  logic            drain_s;
  logic            beat_s;
  logic            start_s;
  logic            stall_last_s;
  logic [8:0]      units_sum_s;
  logic [7:0]      units_sat_s;

  // Datapath decode: beat offer, handshake and start conditions.
  always_comb begin
    have_data_s  = (mem_used > LOW_MARK);
    drain_s      = (state_r == ST_DRAIN);
    tx_valid     = drain_s & have_data_s;
    if (tx_valid) begin
      tx_count = (mem_used > 8'd2) ? 2'd3 : 2'd1;
    end else begin
      tx_count = 2'd0;
    end
    // Scan wins in the counter, so a beat only fires when the counter will actually decrement.
    beat_s       = tx_valid & rx_ready & ~scan;
    flush        = beat_s;
    start_s      = have_data_s & (start_xfer | (AUTO_EN & (mem_used >= HIGH_MARK)));
    stall_last_s = (stall_cnt_r == SW'(STALL_MAX - 1));
    units_sum_s  = {1'b0, units_sent_r} + {7'd0, tx_count};
    if (units_sum_s[8]) begin
      units_sat_s = 8'hFF;
    end else begin
      units_sat_s = units_sum_s[7:0];
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (!tx_valid) begin
          state_nxt_s = ST_DONE;
        end else if (!beat_s && stall_last_s) begin
          state_nxt_s = ST_ERR;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      ST_ERR:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Units-moved and stall counters; units_sent holds through IDLE until the next drain starts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      units_sent_r <= 8'd0;
      stall_cnt_r  <= '0;
    end else if ((state_r == ST_IDLE) && (state_nxt_s == ST_DRAIN)) begin
      units_sent_r <= 8'd0;
      stall_cnt_r  <= '0;
    end else if (beat_s) begin
      units_sent_r <= units_sat_s;
      stall_cnt_r  <= '0;
    end else if (tx_valid && !stall_last_s) begin
      stall_cnt_r  <= stall_cnt_r + SW'(1);
    end else begin
      units_sent_r <= units_sent_r;
      stall_cnt_r  <= stall_cnt_r;
    end
  end

  assign xfer_busy  = drain_s;
  assign xfer_done  = (state_r == ST_DONE);
  assign xfer_err   = (state_r == ST_ERR);
  assign units_sent = units_sent_r;

endmodule

// File: tb/tb_flush_ctrl.sv
// Bench for flush_ctrl: live occupancy-counter model, a transaction-level reference model
// checked every cycle, and directed scenarios with hand-computed literal expectations.
module tb_flush_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] mem_used;
  logic       scan = 1'b0;
  logic       start_xfer = 1'b0;
  logic       rx_ready = 1'b0;
  logic       flush, tx_valid, xfer_busy, xfer_done, xfer_err;
  logic [1:0] tx_count;
  logic [7:0] units_sent;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  flush_ctrl dut (
    .clk(clk), .reset(reset), .mem_used(mem_used), .scan(scan),
    .start_xfer(start_xfer), .rx_ready(rx_ready), .flush(flush),
    .tx_valid(tx_valid), .tx_count(tx_count), .xfer_busy(xfer_busy),
    .xfer_done(xfer_done), .xfer_err(xfer_err), .units_sent(units_sent)
  );

  always #5 clk = ~clk;

  // Memory occupancy counter: scan increments and wins over flush; flush removes 3 or 1.
  always @(posedge clk or negedge reset) begin
    if (!reset) mem_used <= 8'd0;
    else if (scan) mem_used <= (mem_used == 8'd255) ? 8'd255 : mem_used + 8'd1;
    else if (flush) mem_used <= mem_used - ((mem_used > 8'd2) ? 8'd3 : 8'd1);
  end

`ifdef FLUSH_CTRL_AUTO_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  // Reference model: a drain session, its units tally, its run of consecutive stalls, and end pulses.
  bit m_busy, m_done, m_err;
  int m_units, m_stalls;

  function automatic int beat_size(input int occ);
    return (occ > 2) ? 3 : 1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy <= 0; m_done <= 0; m_err <= 0; m_units <= 0; m_stalls <= 0;
    end else if (m_done || m_err) begin
      m_done <= 0; m_err <= 0;
    end else if (!m_busy) begin
      if (mem_used > 0 && (start_xfer || (AUTO && mem_used >= 80))) begin
        m_busy <= 1; m_units <= 0; m_stalls <= 0;
      end
    end else if (mem_used == 0) begin
      m_busy <= 0; m_done <= 1;
    end else if (rx_ready && !scan) begin
      m_units  <= (m_units + beat_size(mem_used) > 255) ? 255 : m_units + beat_size(mem_used);
      m_stalls <= 0;
    end else if (m_stalls + 1 >= 16) begin
      m_busy <= 0; m_err <= 1;
    end else begin
      m_stalls <= m_stalls + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT outputs against the model mid-cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      int occ;
      bit offer;
      occ   = mem_used;
      offer = m_busy && occ > 0;
      chk("tx_valid", tx_valid, offer);
      chk("tx_count", tx_count, offer ? beat_size(occ) : 0);
      chk("flush", flush, offer && rx_ready && !scan);
      chk("xfer_busy", xfer_busy, m_busy);
      chk("xfer_done", xfer_done, m_done);
      chk("xfer_err", xfer_err, m_err);
      chk("units_sent", units_sent, m_units);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic scan_n(input int n);
    scan = 1'b1;
    repeat (n) tick();
    scan = 1'b0;
  endtask

  task automatic kick(input bit rdy);
    rx_ready = rdy; start_xfer = 1'b1;
    tick();
    start_xfer = 1'b0;
  endtask

  int tc_q[$];
  int n_stall;

  // Runs until an end pulse; optional rx_ready hold and scan burst after a given beat count.
  task automatic run_drain(input int hold_after, input int hold_len, input int scan_after,
                           input int scan_len, input int max_cyc,
                           output int beats, output bit done, output bit err);
    int hold_cnt, scan_cnt;
    bit hold_all;
    beats = 0; done = 0; err = 0; hold_cnt = 0; scan_cnt = 0; n_stall = 0;
    hold_all = (hold_after == 0);
    tc_q.delete();
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (xfer_done) done = 1;
      if (xfer_err) err = 1;
      if (done || err) break;
      if (flush) begin beats++; tc_q.push_back(int'(tx_count)); end
      else if (tx_valid) n_stall++;
      @(posedge clk); #1;
      rx_ready = !hold_all; scan = 1'b0;
      if (beats == hold_after && hold_cnt < hold_len) begin rx_ready = 1'b0; hold_cnt++; end
      if (beats == scan_after && scan_cnt < scan_len) begin scan = 1'b1; scan_cnt++; end
    end
    scan = 1'b0;
    if (!done && !err) chk("end_pulse_timeout", 0, 1);
  endtask

  initial begin
    int beats;
    bit done, err;
    repeat (2) tick();
    chk("reset_busy", xfer_busy, 0);
    chk("reset_units", units_sent, 0);
    reset = 1'b1;
    cmp_en = 1'b1;
    tick();

    // Start request with empty memory is ignored.
    kick(1'b1);
    tick();
    chk("ignored_start_busy", xfer_busy, 0);

    // Normal drain of 10 units.
    scan_n(10);
    chk("fill10", mem_used, 10);
    kick(1'b1);
    run_drain(-1, 0, -1, 0, 50, beats, done, err);
    chk("normal_beats", beats, 4);
    chk("normal_tc0", tc_q.size() > 0 ? tc_q[0] : -1, 3);
    chk("normal_tc1", tc_q.size() > 1 ? tc_q[1] : -1, 3);
    chk("normal_tc2", tc_q.size() > 2 ? tc_q[2] : -1, 3);
    chk("normal_tc3", tc_q.size() > 3 ? tc_q[3] : -1, 1);
    chk("normal_done", done, 1);
    chk("normal_units", units_sent, 10);
    chk("normal_mem", mem_used, 0);
    tick();

    // Backpressure for 3 cycles after the first beat.
    scan_n(10);
    kick(1'b1);
    run_drain(1, 3, -1, 0, 50, beats, done, err);
    chk("bp_stalls", n_stall, 3);
    chk("bp_done", done, 1);
    chk("bp_err", err, 0);
    chk("bp_units", units_sent, 10);
    tick();

    // Scan collision mid-drain from 20.
    scan_n(20);
    kick(1'b1);
    run_drain(-1, 0, 2, 2, 60, beats, done, err);
    chk("coll_done", done, 1);
    chk("coll_units", units_sent, 22);
    chk("coll_mem", mem_used, 0);
    tick();

    // Stall abort: receiver never ready.
    scan_n(5);
    kick(1'b0);
    run_drain(0, 1000, -1, 0, 40, beats, done, err);
    chk("stall_err", err, 1);
    chk("stall_done", done, 0);
    chk("stall_cycles", n_stall, 16);
    chk("stall_mem", mem_used, 5);
    chk("stall_units", units_sent, 0);
    tick();
    chk("stall_idle", xfer_busy, 0);

    // Asynchronous reset in the middle of a beat.
    kick(1'b1);
    @(negedge clk);
    chk("pre_reset_flush", flush, 1);
    #2 reset = 1'b0;
    #1;
    chk("rst_flush", flush, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_busy", xfer_busy, 0);
    chk("rst_units", units_sent, 0);
    tick();
    reset = 1'b1;
    tick();
    chk("post_reset_busy", xfer_busy, 0);

    // High-mark behaviour without start_xfer.
    rx_ready = 1'b1;
    scan_n(80);
    if (AUTO) begin
      run_drain(-1, 0, -1, 0, 80, beats, done, err);
      chk("auto_done", done, 1);
      chk("auto_units", units_sent, 80);
      chk("auto_mem", mem_used, 0);
    end else begin
      repeat (3) tick();
      chk("noauto_busy", xfer_busy, 0);
      chk("noauto_mem", mem_used, 80);
    end
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
